// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default bubble word,
// fetch FSM state encoding, PC step and the prefetch FIFO entry layout.
package fetch_unit_pkg;

   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

   // Fetch FSM states (legacy-compatible encoding)
   localparam logic [0:0] FETCH   = 1'b0;
   localparam logic [0:0] DISCARD = 1'b1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   // Word-align a fetch address
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {instr, pc}, synchronous push/pop/flush.
// Simultaneous push and pop is allowed even when full (head is read before
// the slot is rewritten).
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [63:0]                wdata,
   input  logic                       pop,
   input  logic                       flush,
   output logic [63:0]                rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   // Qualify requests against occupancy and flush
   always_comb begin
      empty   = (count == '0);
      full    = (count == CW'(DEPTH));
      do_pop  = pop && !empty && !flush;
      do_push = push && (!full || do_pop) && !flush;
      rdata   = mem[rd_ptr];
   end

   // Storage array write
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, one-outstanding req/ack memory port,
// prefetch FIFO and registered ibus output with hold and redirect.
// Optional macro FETCH_STALL_CNT_EN adds the stall_cnt bubble counter port.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        hold,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] ibus,
   output logic [31:0] ibus_pc,
   output logic        ibus_valid
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [0:0]    state;
   logic [0:0]    state_next;
   logic [31:0]   fetch_pc;
   logic [31:0]   fetch_pc_next;
   logic [31:0]   addr_next;
   logic          req_next;
   logic          req_pending;
   logic          ack_taken;
   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic          fifo_full;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   fetch_entry_t  head;
   fetch_entry_t  tail_entry;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (tail_entry),
      .pop   (pop),
      .flush (redirect),
      .rdata (head),
      .count (count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Next-state, next-PC and request issue decisions
   always_comb begin
      ack_taken   = imem_req && imem_ack;
      req_pending = imem_req && !imem_ack;
      pop         = !redirect && !hold && !fifo_empty;
      push        = ack_taken && (state == FETCH) && !redirect && (!fifo_full || pop);
      tail_entry  = '{instr: imem_rdata, pc: fetch_pc};
      count_next  = redirect ? '0 : (count + CW'(push) - CW'(pop));

      state_next    = state;
      fetch_pc_next = fetch_pc;
      if (redirect) begin
         fetch_pc_next = align_pc(redirect_pc);
         state_next    = req_pending ? DISCARD : FETCH;
      end else if (ack_taken) begin
         if (state == FETCH) fetch_pc_next = fetch_pc + PC_INC;
         state_next = FETCH;
      end

      // A slot is reserved at issue, so only count the FIFO once nothing is in flight
      req_next  = req_pending || ((state_next == FETCH) && (count_next < CW'(DEPTH)));
      addr_next = req_pending ? imem_addr : fetch_pc_next;
   end

   // FSM, fetch PC and memory request registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= FETCH;
         fetch_pc  <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         state     <= state_next;
         fetch_pc  <= fetch_pc_next;
         imem_req  <= req_next;
         imem_addr <= addr_next;
      end
   end

   // Registered instruction output to the datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ibus       <= NOP_WORD;
         ibus_pc    <= '0;
         ibus_valid <= 1'b0;
      end else if (redirect) begin
         ibus       <= NOP_WORD;
         ibus_valid <= 1'b0;
      end else if (!hold) begin
         if (!fifo_empty) begin
            ibus       <= head.instr;
            ibus_pc    <= head.pc;
            ibus_valid <= 1'b1;
         end else begin
            ibus       <= NOP_WORD;
            ibus_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_STALL_CNT_EN
   // Saturating count of bubbles issued while downstream was ready
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (!hold && fifo_empty && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory responder with variable latency
// drives the req/ack port, and a queue-based reference model predicts ibus,
// the request handshake and (when enabled) the stall counter every cycle.
module tb_fetch_unit;

   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        hold;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] ibus;
   logic [31:0] ibus_pc;
   logic        ibus_valid;
`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   fetch_unit #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH),
      .NOP_WORD (NOP_WORD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .hold        (hold),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ibus        (ibus),
      .ibus_pc     (ibus_pc),
      .ibus_valid  (ibus_valid)
`ifdef FETCH_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memval(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Reference model: FIFO contents as a queue, plus fetch address bookkeeping
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } word_t;

   word_t       q[$];
   logic [31:0] m_fpc;
   logic [31:0] m_ibus;
   logic [31:0] m_ibus_pc;
   logic        m_valid;
   logic        m_disc;
   logic        m_req;
   logic [31:0] m_addr;
   logic [31:0] m_stall;
   bit          have_exp = 0;

   int unsigned wcnt    = 0;
   int unsigned cur_lat = 0;
   bit          dir_hit = 0;

   task automatic cycle(input int unsigned lat_min, input int unsigned lat_max,
                        input int unsigned hold_pct, input int unsigned redir_pm,
                        input int unsigned rst_pm, input bit dir_en,
                        input logic [31:0] dir_addr);
      logic        req_s, ack_s, hold_s, redir_s, rst_s;
      logic [31:0] rpc_s, rdata_s, addr_s;
      word_t       w;

      @(negedge clk);
      if (have_exp) begin
         check("ibus", ibus, m_ibus);
         check("ibus_pc", ibus_pc, m_ibus_pc);
         check("ibus_valid", 32'(ibus_valid), 32'(m_valid));
         check("imem_req", 32'(imem_req), 32'(m_req));
         if (m_req) check("imem_addr", imem_addr, m_addr);
`ifdef FETCH_STALL_CNT_EN
         check("stall_cnt", stall_cnt, m_stall);
`endif
      end

      rst_n    = ($urandom_range(999) >= rst_pm);
      hold     = ($urandom_range(99) < hold_pct);
      redirect = ($urandom_range(999) < redir_pm);
      case ($urandom_range(3))
         0:       redirect_pc = $urandom;
         1:       redirect_pc = 32'h0000_0103;
         2:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
         default: redirect_pc = 32'($urandom_range(255));
      endcase

      if (imem_req) begin
         if (wcnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
         if (wcnt >= cur_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = memval(imem_addr);
            wcnt       = 0;
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wcnt++;
         end
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
      end

      // Directed redirect while a request for dir_addr is still waiting
      if (dir_en && !dir_hit && imem_req && !imem_ack && (imem_addr == dir_addr)) begin
         rst_n       = 1'b1;
         hold        = 1'b0;
         redirect    = 1'b1;
         redirect_pc = 32'h0000_0103;
         dir_hit     = 1;
      end

      req_s   = imem_req;
      ack_s   = imem_ack;
      addr_s  = imem_addr;
      hold_s  = hold;
      redir_s = redirect;
      rst_s   = rst_n;
      rpc_s   = redirect_pc;
      rdata_s = imem_rdata;

      @(posedge clk);
      have_exp = 1;
      if (!rst_s) begin
         q.delete();
         m_fpc     = RESET_PC;
         m_disc    = 0;
         m_ibus    = NOP_WORD;
         m_ibus_pc = '0;
         m_valid   = 0;
         m_req     = 0;
         m_addr    = RESET_PC;
         m_stall   = '0;
         wcnt      = 0;
      end else begin
         if (!hold_s && q.size() == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (redir_s) begin
            q.delete();
            m_ibus  = NOP_WORD;
            m_valid = 0;
            m_disc  = req_s && !ack_s ? 1'b1 : 1'b0;
            m_fpc   = {rpc_s[31:2], 2'b00};
         end else begin
            if (!hold_s) begin
               if (q.size() > 0) begin
                  w         = q.pop_front();
                  m_ibus    = w.instr;
                  m_ibus_pc = w.pc;
                  m_valid   = 1;
               end else begin
                  m_ibus  = NOP_WORD;
                  m_valid = 0;
               end
            end
            if (req_s && ack_s) begin
               if (m_disc) begin
                  m_disc = 0;
               end else begin
                  q.push_back('{instr: rdata_s, pc: m_fpc});
                  m_fpc = m_fpc + 32'd4;
               end
            end
         end
         if (req_s && !ack_s) begin
            m_req  = 1;
            m_addr = addr_s;
         end else begin
            m_req  = !m_disc && (q.size() < DEPTH);
            m_addr = m_fpc;
         end
      end
   endtask

   task automatic run_phase(input int unsigned lat_min, input int unsigned lat_max,
                            input int unsigned hold_pct, input int unsigned redir_pm,
                            input int unsigned rst_pm, input int unsigned ncyc,
                            input bit dir_en, input logic [31:0] dir_addr);
      for (int i = 0; i < int'(ncyc); i++) begin
         cycle(lat_min, lat_max, hold_pct, redir_pm, rst_pm, dir_en, dir_addr);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      hold        = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;

      // reset, then zero-wait streaming
      run_phase(0, 0, 0, 0, 1000, 3, 0, '0);
      run_phase(0, 0, 0, 0, 0, 40, 0, '0);
      // back-pressure with fast memory
      run_phase(0, 0, 60, 0, 0, 200, 0, '0);
      // fixed 3-cycle latency: bubbles between words
      run_phase(3, 3, 0, 0, 0, 60, 0, '0);
      // reset, then redirect to 0x103 while the 0x10 request is pending
      run_phase(3, 3, 0, 0, 1000, 2, 0, '0);
      run_phase(3, 3, 0, 0, 0, 60, 1, 32'h0000_0010);
      check("dir_redirect_hit", 32'(dir_hit), 32'd1);
      // mixed random traffic with redirects
      run_phase(0, 3, 30, 50, 0, 1500, 0, '0);
      // same, with occasional reset mid-request
      run_phase(0, 3, 30, 30, 10, 1500, 0, '0);
      run_phase(0, 2, 0, 0, 0, 20, 0, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the 3-stage datapath and drives its 32-bit instruction input. Keeps the fetch PC and issues one-outstanding req/ack reads to instruction memory. Buffers returned words in a small prefetch FIFO and presents one instruction per cycle on ibus. Handles hold (back-pressure) and PC redirect with in-flight discard.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
DEPTH, 2, prefetch FIFO entries (power of 2, >=2)
NOP_WORD, 32'h0000_0000, word driven on ibus when no valid instruction

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
imem_req  output  1  read request; held high until imem_ack
imem_addr  output  32  word-aligned read address; stable while imem_req=1
imem_ack  input  1  read data valid this cycle; completes request
imem_rdata  input  32  instruction word, valid with imem_ack
hold  input  1  downstream cannot accept; ibus must not advance
redirect  input  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 00)
ibus  output  32  registered instruction to datapath
ibus_pc  output  32  address of word on ibus
ibus_valid  output  1  ibus holds a real instruction (0 = NOP bubble)

Behaviour:
- Clock and reset: one clock, clk; reset is rst_n, synchronous, active-low. rst_n=0 sampled at an edge → fetch_pc=RESET_PC, FIFO empty, in-flight=0, state FETCH, imem_req=0, ibus=NOP_WORD, ibus_pc=0, ibus_valid=0. Reset overrides every other input, including mid-request; a pending ack is not tracked afterward.
- FSM states:
  - FETCH: normal operation.
  - DISCARD: request outstanding for a stale address; data is dropped.
- Request issue (FETCH): imem_req=1, imem_addr=fetch_pc whenever count+inflight<DEPTH. Once raised, req and addr stay constant until ack.
- Ack in FETCH: imem_rdata pushed with tag fetch_pc; fetch_pc+=4 (32-bit wrap, FFFF_FFFC→0000_0000). Next request may assert the cycle after the ack edge.
- Output register (edge, no redirect):
  - hold=1 → ibus, ibus_pc, ibus_valid unchanged; FIFO not popped.
  - hold=0 and FIFO non-empty → load head, ibus_valid=1, pop.
  - hold=0 and FIFO empty → ibus=NOP_WORD, ibus_valid=0, ibus_pc unchanged.
- Latency: ack sampled at edge N with empty FIFO and hold=0 → word on ibus after edge N+1. No combinational path from imem_rdata to ibus.
- Simultaneous push and pop in one edge is legal; count unchanged. Full FIFO plus hold → no new request issued. Ack never arrives when full, because inflight is reserved at issue.
- Redirect (priority over hold and ack):
  - Flush FIFO.
  - ibus=NOP_WORD, ibus_valid=0.
  - fetch_pc={redirect_pc[31:2],2'b00}.
  - If a request is outstanding and not acked this cycle → DISCARD. In DISCARD, imem_req stays high on the old address; on ack the data is dropped and the state returns to FETCH; the next request uses the new fetch_pc.
  - If ack coincides with redirect → data dropped, stay in FETCH.
- Redirect while in DISCARD: update fetch_pc only; remain in DISCARD.

Optional Feature:
FETCH_STALL_CNT_EN: adds output stall_cnt[31:0]. Cleared on reset; increments each cycle where hold=0 and the FIFO is empty (a bubble issued); saturates at FFFF_FFFF. Without the macro, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: NOP_WORD default, fetch FSM state encoding (FETCH, DISCARD), PC increment constant 4.
- One natural sub-module: fetch_fifo — DEPTH×64-bit (instr + pc) synchronous FIFO with push, pop, flush, count, empty/full. The rest is the PC/FSM/output register in fetch_unit.

Test Plan:
- Reset, then zero-wait memory (ack the cycle after req), hold=0 → imem_addr 0,4,8…; ibus shows mem[0] with ibus_pc=0 after 2 edges from first ack, then one word per cycle thereafter; ibus_valid=1.
- hold=1 for 5 cycles mid-stream → ibus constant; at most DEPTH words buffered; imem_req drops once full; on release, words resume in order with no loss or duplication.
- 3-cycle memory latency → ibus_valid toggles with NOP_WORD bubbles between instructions; ibus_pc increments by 4 per valid word.
- redirect (redirect_pc=0x0000_0103) while a request for 0x10 is pending → DISCARD; 0x10 data never appears; next imem_addr=0x0000_0100; first valid ibus_pc=0x100.
- redirect in the same cycle as ack and hold=1 → FIFO flushed, ibus=NOP_WORD, ibus_valid=0; fetch restarts at redirect_pc.
- rst_n=0 asserted while a request is outstanding → imem_req=0 next cycle; restart at RESET_PC; ibus=NOP_WORD, ibus_valid=0. With FETCH_STALL_CNT_EN, stall_cnt=0 after reset and counts 2 for a 3-cycle-latency fetch.
